lsu_ctrl: RTL and testbench

- Sequences every load/store issued by the decode stage onto the single-port data bus. The bus uses a req/gnt address phase and an rvalid response phase.
- Stalls the pipeline while an access is outstanding.
- Generates byte enables and store-data lanes.
- Extracts and sign- or zero-extends load data, then writes it back to the register file.
- Sits between the ID-EX register and the data memory / interconnect.

---
 rtl/lsu_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: sequences one data-bus access at a time
// (req/gnt then rvalid), builds byte lanes and extends load results.
package milano_pkg;
  typedef enum logic [3:0] {
    LSU_NONE,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_opt_e;
endpackage

module lsu_ctrl
  import milano_pkg::*;
#(
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  lsu_opt_e    lsu_operate_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_rd_addr_i,
  output logic        lsu_busy_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        rd_wr_en_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_wdata_o,
  output logic        misaligned_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  // 0 = byte, 1 = half, 2 = word
  function automatic logic [1:0] f_size(lsu_opt_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: f_size = 2'd0;
      LSU_LH, LSU_LHU, LSU_SH: f_size = 2'd1;
      default:                 f_size = 2'd2;
    endcase
  endfunction

  state_e      r_state;
  state_e      w_next;
  lsu_opt_e    r_op;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;

  logic        w_accept;
  logic        w_misal;
  logic        w_abort;
  logic        w_wb;
  logic        w_req;
  logic [1:0]  w_isz;
  logic [1:0]  w_rsz;
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic [31:0] w_shift;
  logic [31:0] w_ext;

  assign w_isz = f_size(lsu_operate_i);
  assign w_rsz = f_size(r_op);

  assign w_misal = (w_isz == 2'd1 && lsu_addr_i[0]) ||
                   (w_isz == 2'd2 && lsu_addr_i[1:0] != 2'b00);

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_abort  = 1'b0;
    w_wb     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lsu_req_i && lsu_operate_i != LSU_NONE) begin
          w_accept = 1'b1;
          if (!w_misal) w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (data_gnt_i) begin
          w_next = S_WAIT;
        end else if (r_cnt == 8'(GNT_TIMEOUT - 1)) begin
          w_next  = S_IDLE;
          w_abort = 1'b1;
        end
      end
      S_WAIT: begin
        if (data_rvalid_i) begin
          w_next = S_IDLE;
          w_wb   = !r_we;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign lsu_busy_o = (r_state != S_IDLE) || (w_accept && !w_misal);

  always_comb begin
    case (w_rsz)
      2'd0: begin
        w_be = 4'b0001 << r_addr[1:0];
        w_wd = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be = 4'b0011 << r_addr[1:0];
        w_wd = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = r_wdata;
      end
    endcase
  end

  assign w_shift = data_rdata_i >> {r_addr[1:0], 3'b000};

  always_comb begin
    case (r_op)
      LSU_LB:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      LSU_LBU: w_ext = {24'd0, w_shift[7:0]};
      LSU_LH:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      LSU_LHU: w_ext = {16'd0, w_shift[15:0]};
      default: w_ext = data_rdata_i;
    endcase
  end

  assign w_req        = (r_state == S_REQ);
  assign data_req_o   = w_req;
  assign data_we_o    = w_req & r_we;
  assign data_be_o    = w_req ? w_be : 4'b0000;
  assign data_addr_o  = w_req ? {r_addr[31:2], 2'b00} : 32'd0;
  assign data_wdata_o = w_req ? w_wd : 32'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_op         <= LSU_NONE;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_rd         <= 5'd0;
      r_cnt        <= 8'd0;
      rd_wr_en_o   <= 1'b0;
      rd_addr_o    <= 5'd0;
      rd_wdata_o   <= 32'd0;
      misaligned_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      r_state      <= w_next;
      rd_wr_en_o   <= w_wb;
      misaligned_o <= w_accept && w_misal;
      err_o        <= w_abort;
      if (w_accept) begin
        r_op    <= lsu_operate_i;
        r_we    <= lsu_we_i;
        r_addr  <= lsu_addr_i;
        r_wdata <= lsu_wdata_i;
        r_rd    <= lsu_rd_addr_i;
      end
      // counts stalled REQ cycles; cleared whenever REQ is left
      if (w_req && !data_gnt_i && !w_abort) r_cnt <= r_cnt + 8'd1;
      else                                  r_cnt <= 8'd0;
      if (w_wb) begin
        rd_addr_o  <= r_rd;
        rd_wdata_o <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a transaction-level expectation model
// and a per-cycle bus / writeback monitor.
module tb_lsu_ctrl;
  import milano_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  lsu_opt_e    lsu_operate_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [4:0]  lsu_rd_addr_i;
  logic        lsu_busy_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        rd_wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_wdata_o;
  logic        misaligned_o;
  logic        err_o;

  lsu_ctrl #(.GNT_TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_operate_i(lsu_operate_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_rd_addr_i(lsu_rd_addr_i),
    .lsu_busy_o(lsu_busy_o), .data_req_o(data_req_o),
    .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rvalid_i(data_rvalid_i),
    .data_rdata_i(data_rdata_i), .rd_wr_en_o(rd_wr_en_o),
    .rd_addr_o(rd_addr_o), .rd_wdata_o(rd_wdata_o),
    .misaligned_o(misaligned_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  wb_t         wbq[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          req_cnt = 0;
  logic        exp_valid = 1'b0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_be = 4'd0;
  logic [31:0] exp_addr = 32'd0;
  logic [31:0] exp_wd = 32'd0;
  logic [3:0]  last_be = 4'd0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] last_wd = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int m_size(lsu_opt_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return 1;
      LSU_LH, LSU_LHU, LSU_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic logic m_store(lsu_opt_e op);
    return op == LSU_SB || op == LSU_SH || op == LSU_SW;
  endfunction

  function automatic logic m_mis(lsu_opt_e op, logic [31:0] a);
    return (a % m_size(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(lsu_opt_e op, logic [31:0] a);
    int n;
    n = m_size(op);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wd(lsu_opt_e op, logic [31:0] w);
    case (m_size(op))
      1:       return 32'(w[7:0]) * 32'h0101_0101;
      2:       return 32'(w[15:0]) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(lsu_opt_e op, logic [31:0] a,
                                       logic [31:0] rdata);
    logic [31:0] s;
    int v;
    s = rdata >> (8 * (a % 4));
    case (op)
      LSU_LB:  begin v = int'(s % 256);   if (v > 127)   v -= 256;   end
      LSU_LBU: v = int'(s % 256);
      LSU_LH:  begin v = int'(s % 65536); if (v > 32767) v -= 65536; end
      LSU_LHU: v = int'(s % 65536);
      default: v = int'(s);
    endcase
    return 32'(v);
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (data_req_o) begin
        req_cnt++;
        if (!exp_valid) chk("req_unexpected", {31'd0, data_req_o}, 32'd0);
        else begin
          chk("bus_addr", data_addr_o, exp_addr);
          chk("bus_be", {28'd0, data_be_o}, {28'd0, exp_be});
          chk("bus_we", {31'd0, data_we_o}, {31'd0, exp_we});
          if (exp_we) chk("bus_wdata", data_wdata_o, exp_wd);
          last_be   = data_be_o;
          last_addr = data_addr_o;
          last_wd   = data_wdata_o;
        end
      end
      if (rd_wr_en_o) begin
        if (wbq.size() == 0)
          chk("wb_unexpected", {31'd0, rd_wr_en_o}, 32'd0);
        else begin
          wb_t e;
          e = wbq.pop_front();
          chk("wb_rd", {27'd0, rd_addr_o}, {27'd0, e.rd});
          chk("wb_data", rd_wdata_o, e.val);
        end
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input lsu_opt_e op, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] rd,
                       input logic [31:0] rdata);
    logic mis;
    mis           = m_mis(op, a);
    lsu_req_i     = 1'b1;
    lsu_operate_i = op;
    lsu_we_i      = m_store(op);
    lsu_addr_i    = a;
    lsu_wdata_i   = w;
    lsu_rd_addr_i = rd;
    exp_valid     = !mis;
    exp_we        = m_store(op);
    exp_addr      = {a[31:2], 2'b00};
    exp_be        = m_be(op, a);
    exp_wd        = m_wd(op, w);
    req_cnt       = 0;
    if (!mis && !m_store(op)) wbq.push_back('{rd, m_ld(op, a, rdata)});
  endtask

  task automatic idle_inputs();
    lsu_req_i     = 1'b0;
    lsu_operate_i = LSU_NONE;
    lsu_addr_i    = 32'hDEAD_BEEF;
    lsu_wdata_i   = 32'h5555_AAAA;
  endtask

  task automatic access(input lsu_opt_e op, input logic [31:0] a,
                        input logic [31:0] w, input logic [4:0] rd,
                        input logic [31:0] rdata, input int gd,
                        input int rvd);
    logic mis;
    mis = m_mis(op, a);
    issue(op, a, w, rd, rdata);
    @(negedge clk_i);
    chk("busy_accept", {31'd0, lsu_busy_o}, {31'd0, !mis});
    next_cyc();
    idle_inputs();
    if (mis) begin
      @(negedge clk_i);
      chk("mis_pulse", {31'd0, misaligned_o}, 32'd1);
      chk("mis_busy", {31'd0, lsu_busy_o}, 32'd0);
      next_cyc();
      @(negedge clk_i);
      chk("mis_pulse_end", {31'd0, misaligned_o}, 32'd0);
      chk("mis_no_req", 32'(req_cnt), 32'd0);
      next_cyc();
      return;
    end
    for (int i = 0; i < gd; i++) begin
      @(negedge clk_i);
      chk("busy_req", {31'd0, lsu_busy_o}, 32'd1);
      next_cyc();
    end
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    chk("busy_gnt", {31'd0, lsu_busy_o}, 32'd1);
    next_cyc();
    data_gnt_i = 1'b0;
    chk("req_cycles", 32'(req_cnt), 32'(gd + 1));
    for (int i = 0; i < rvd; i++) begin
      @(negedge clk_i);
      chk("busy_wait", {31'd0, lsu_busy_o}, 32'd1);
      chk("wait_no_wb", {31'd0, rd_wr_en_o}, 32'd0);
      next_cyc();
    end
    data_rvalid_i = 1'b1;
    data_rdata_i  = rdata;
    @(negedge clk_i);
    chk("busy_rvalid", {31'd0, lsu_busy_o}, 32'd1);
    next_cyc();
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'h1357_9BDF;
    @(negedge clk_i);
    chk("busy_done", {31'd0, lsu_busy_o}, 32'd0);
    chk("wb_strobe", {31'd0, rd_wr_en_o}, {31'd0, !m_store(op)});
    next_cyc();
    chk("wb_drained", 32'(wbq.size()), 32'd0);
    exp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i         = 1'b1;
    lsu_we_i      = 1'b0;
    lsu_rd_addr_i = 5'd0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'd0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_busy", {31'd0, lsu_busy_o}, 32'd0);
    chk("rst_req", {31'd0, data_req_o}, 32'd0);
    chk("rst_wb", {31'd0, rd_wr_en_o}, 32'd0);
    chk("rst_wdata", rd_wdata_o, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
    next_cyc();

    // LSU_NONE with a request is ignored
    lsu_req_i = 1'b1;
    @(negedge clk_i);
    chk("none_busy", {31'd0, lsu_busy_o}, 32'd0);
    next_cyc();
    idle_inputs();
    @(negedge clk_i);
    chk("none_req", {31'd0, data_req_o}, 32'd0);
    next_cyc();

    access(LSU_LB, 32'h1003, 32'h0, 5'd3, 32'h80AA_BBCC, 0, 0);
    chk("t1_rd_wdata", rd_wdata_o, 32'hFFFF_FF80);
    chk("t1_be", {28'd0, last_be}, 32'h8);
    chk("t1_addr", last_addr, 32'h1000);

    access(LSU_SH, 32'h2002, 32'h1234_ABCD, 5'd0, 32'h0, 3, 1);
    chk("t2_wdata", last_wd, 32'hABCD_ABCD);
    chk("t2_be", {28'd0, last_be}, 32'hC);
    chk("t2_addr", last_addr, 32'h2000);

    access(LSU_LHU, 32'h3002, 32'h0, 5'd7, 32'h8001_0000, 1, 2);
    chk("t3_lhu", rd_wdata_o, 32'h0000_8001);
    access(LSU_LH, 32'h3002, 32'h0, 5'd8, 32'h8001_0000, 0, 0);
    chk("t3_lh", rd_wdata_o, 32'hFFFF_8001);

    access(LSU_LW, 32'h4001, 32'h0, 5'd9, 32'h0, 0, 0);
    access(LSU_SB, 32'h5001, 32'h0000_00A5, 5'd0, 32'h0, 0, 0);
    access(LSU_LBU, 32'h5002, 32'h0, 5'd10, 32'h00F0_0000, 2, 0);
    access(LSU_SW, 32'h6000, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 0);
    access(LSU_SH, 32'h6001, 32'h0, 5'd0, 32'h0, 0, 0);

    // grant never arrives: abort after 16 REQ cycles
    issue(LSU_LB, 32'h7000, 32'h0, 5'd11, 32'h0);
    wbq.delete();
    next_cyc();
    idle_inputs();
    n = 0;
    while (n < 40) begin
      @(negedge clk_i);
      if (!data_req_o) break;
      n++;
      next_cyc();
    end
    chk("to_req_cycles", 32'(req_cnt), 32'd16);
    chk("to_err", {31'd0, err_o}, 32'd1);
    chk("to_busy", {31'd0, lsu_busy_o}, 32'd0);
    next_cyc();
    @(negedge clk_i);
    chk("to_err_end", {31'd0, err_o}, 32'd0);
    chk("to_no_wb", {31'd0, rd_wr_en_o}, 32'd0);
    next_cyc();
    exp_valid = 1'b0;
    access(LSU_LW, 32'h0, 32'h0, 5'd12, 32'h89AB_CDEF, 0, 0);
    chk("t5_lw", rd_wdata_o, 32'h89AB_CDEF);

    // reset while waiting for rvalid drops the load
    issue(LSU_LW, 32'h8000, 32'h0, 5'd13, 32'h1111_2222);
    wbq.delete();
    next_cyc();
    idle_inputs();
    data_gnt_i = 1'b1;
    next_cyc();
    data_gnt_i = 1'b0;
    rst_i      = 1'b1;
    next_cyc();
    rst_i         = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1111_2222;
    @(negedge clk_i);
    chk("t6_wb", {31'd0, rd_wr_en_o}, 32'd0);
    chk("t6_wdata", rd_wdata_o, 32'd0);
    chk("t6_rd", {27'd0, rd_addr_o}, 32'd0);
    chk("t6_req", {31'd0, data_req_o}, 32'd0);
    chk("t6_be", {28'd0, data_be_o}, 32'd0);
    chk("t6_addr", data_addr_o, 32'd0);
    chk("t6_err", {31'd0, err_o}, 32'd0);
    chk("t6_busy", {31'd0, lsu_busy_o}, 32'd0);
    next_cyc();
    data_rvalid_i = 1'b0;
    @(negedge clk_i);
    chk("t6_wb_late", {31'd0, rd_wr_en_o}, 32'd0);
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
